// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared op codes, funct codes, aluop codes and the state
//                encoding for the execute-stage controller.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Op codes understood by the gate-level ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // R-type funct field values
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Main-decoder aluop values
  localparam logic [1:0] AOP_ADD     = 2'b00;
  localparam logic [1:0] AOP_SUB     = 2'b01;
  localparam logic [1:0] AOP_FUNCT   = 2'b10;
  localparam logic [1:0] AOP_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_exec_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage_if
//  Description : Request, ALU and result buses of the execute stage. The
//                slave modport is the stage itself; the master modport is
//                its environment (upstream, ALU and downstream together).
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_exec_stage_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_aluop;
  logic [5:0]       in_funct;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_overflow;
  logic             out_cout;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_aluop, in_funct, in_a, in_b,
    output in_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_cout,
    output out_valid, out_result, out_zero, out_overflow, out_cout, out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_aluop, in_funct, in_a, in_b,
    input  in_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_cout,
    input  out_valid, out_result, out_zero, out_overflow, out_cout, out_illegal,
    output out_ready
  );

endinterface
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_decode
//  Description : Combinational ALU control decode from (aluop, funct) to the
//                ALU op code, an slt marker and an illegal flag.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] op,
  output logic       is_slt,
  output logic       illegal
);

  // Map the request onto an ALU op; anything unrecognised is illegal
  always_comb begin
    op      = ALU_AND;
    is_slt  = 1'b0;
    illegal = 1'b0;
    case (aluop)
      AOP_ADD: op = ALU_ADD;
      AOP_SUB: op = ALU_SUB;
      AOP_FUNCT: begin
        case (funct)
          FN_ADD: op = ALU_ADD;
          FN_SUB: op = ALU_SUB;
          FN_AND: op = ALU_AND;
          FN_OR:  op = ALU_OR;
          FN_SLT: begin
            op     = ALU_SLT;
            is_slt = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_exec_stage
//  Description : Execute-stage controller. Accepts a decoded request, holds
//                operands on the ALU for SETTLE_CYCLES, captures a corrected
//                result with flags and offers it downstream.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_stage_if.slave bus
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic             is_slt_q, is_slt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;
  logic             illegal_q, illegal_d;

  logic [2:0]       dec_op;
  logic             dec_is_slt;
  logic             dec_illegal;
  logic             accept;
  logic             ovf_raw;
  logic             a_msb, b_msb, r_msb;

  alu_ctrl_decode u_decode (
    .aluop   (bus.in_aluop),
    .funct   (bus.in_funct),
    .op      (dec_op),
    .is_slt  (dec_is_slt),
    .illegal (dec_illegal)
  );

  assign bus.in_ready = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
  assign accept       = bus.in_valid & bus.in_ready;

  // Signed overflow of the held operation, judged from the latched operand MSBs
  always_comb begin
    a_msb = alu_a_q[WIDTH-1];
    b_msb = alu_b_q[WIDTH-1];
    r_msb = bus.alu_result[WIDTH-1];
    case (alu_op_q)
      ALU_ADD:          ovf_raw = (a_msb == b_msb) & (r_msb != a_msb);
      ALU_SUB, ALU_SLT: ovf_raw = (a_msb != b_msb) & (r_msb != a_msb);
      default:          ovf_raw = 1'b0;
    endcase
  end

  // Next-state, operand latching and result capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_op_d  = alu_op_q;
    is_slt_d  = is_slt_q;
    res_d     = res_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    cout_d    = cout_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (dec_illegal) begin
            // Illegal requests skip the ALU and report immediately
            res_d     = '0;
            zero_d    = 1'b1;
            ovf_d     = 1'b0;
            cout_d    = 1'b0;
            illegal_d = 1'b1;
            state_d   = DONE;
          end else begin
            alu_a_d  = bus.in_a;
            alu_b_d  = bus.in_b;
            alu_op_d = dec_op;
            is_slt_d = dec_is_slt;
            cnt_d    = CNT_LOAD;
            state_d  = SETTLE;
          end
        end else if (state_q == DONE && bus.out_ready) begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (is_slt_q) begin
            // The ALU computes a-b for slt; sign xor overflow gives true less-than
            res_d  = {{(WIDTH-1){1'b0}}, r_msb ^ ovf_raw};
            ovf_d  = 1'b0;
            cout_d = 1'b0;
          end else if (alu_op_q == ALU_ADD || alu_op_q == ALU_SUB) begin
            res_d  = bus.alu_result;
            ovf_d  = ovf_raw;
            cout_d = bus.alu_cout;
          end else begin
            res_d  = bus.alu_result;
            ovf_d  = 1'b0;
            cout_d = 1'b0;
          end
          zero_d    = (res_d == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      is_slt_q  <= 1'b0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cout_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_op_q  <= alu_op_d;
      is_slt_q  <= is_slt_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      cout_q    <= cout_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_result   = res_q;
  assign bus.out_zero     = zero_q;
  assign bus.out_overflow = ovf_q;
  assign bus.out_cout     = cout_q;
  assign bus.out_illegal  = illegal_q;

endmodule
`default_nettype wire

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Execute-stage controller that sits directly upstream of the 32-bit gate-level ALU and consumes its outputs.
- Accepts a decoded instruction slice (aluop, funct, operands) over a valid/ready handshake.
- Translates it into the ALU's 3-bit op code and holds operands stable while the ALU settles.
- Captures a corrected result and flags into an output register, then presents them downstream with valid/ready.

Parameters:
WIDTH, 32, operand/result width in bits (must match the ALU)
SETTLE_CYCLES, 4, clock cycles the ALU inputs are held before capture; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream request valid
in_ready  output  1  stage can accept a request this cycle
in_aluop  input  2  00=add (lw/sw), 01=sub (beq), 10=use funct, 11=illegal
in_funct  input  6  R-type funct field
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
alu_a  output  WIDTH  operand A driven to the ALU
alu_b  output  WIDTH  operand B driven to the ALU
alu_op  output  3  ALU op code: 000 and, 001 or, 010 add, 110 sub, 111 slt
alu_result  input  WIDTH  ALU result
alu_cout  input  1  ALU carry out
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_result  output  WIDTH  registered final result
out_zero  output  1  out_result == 0
out_overflow  output  1  signed overflow (add/sub only)
out_cout  output  1  carry out (add/sub only, else 0)
out_illegal  output  1  request decoded as illegal

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE. All outputs and internal registers are 0, except in_ready=1 combinationally in IDLE. Reset mid-operation discards the in-flight request with no output.
- Decode (combinational, from in_aluop/in_funct at accept):
  - aluop 00 -> 010.
  - aluop 01 -> 110.
  - aluop 10 with funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111 (is_slt=1).
  - Any other funct, or aluop 11 -> illegal.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Accept = in_valid & in_ready.
- IDLE:
  - Legal accept: latch in_a/in_b into alu_a/alu_b and the decoded op into alu_op. Load cnt=SETTLE_CYCLES-1. Go to SETTLE.
  - Illegal accept: out_result=0, out_zero=1, out_overflow=0, out_cout=0, out_illegal=1. Go to DONE (latency 1).
- SETTLE:
  - alu_a/alu_b/alu_op held constant.
  - cnt!=0: decrement.
  - cnt==0: capture output registers and go to DONE.
  - Capture occurs SETTLE_CYCLES edges after the accept edge. in_valid is ignored in this state.
- Capture rules (r = alu_result, a31/b31 = latched operand MSBs):
  - add: ovf = (a31==b31) & (r[31]!=a31).
  - sub/slt: ovf = (a31!=b31) & (r[31]!=a31).
  - and/or: ovf = 0.
  - slt: out_result = {WIDTH-1 zeros, r[31]^ovf}; out_overflow=0; out_cout=0.
  - add/sub: out_result = r; out_overflow = ovf; out_cout = alu_cout.
  - and/or: out_result = r; out_cout = 0.
  - out_zero is computed by this stage from the captured out_result, not taken from the ALU. out_illegal = 0.
- DONE:
  - out_valid=1. All out_* held stable while out_ready=0.
  - out_ready=1 with no accept: go to IDLE; out_valid=0 next cycle.
  - out_ready=1 with a simultaneous accept: go directly to SETTLE (or to DONE if illegal). This allows back-to-back issue.
- alu_a/alu_b/alu_op keep their last values in IDLE/DONE until the next accept.
- Throughput: one request per SETTLE_CYCLES+1 cycles with back-to-back issue.

Decomposition:
- Shared package alu_pkg: ALU op constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT), funct constants (FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT), aluop constants, state enum (IDLE, SETTLE, DONE).
- One combinational sub-module, alu_ctrl_decode: (aluop, funct) -> (op[2:0], is_slt, illegal).

Test Plan:
- aluop=10, funct=100000, a=512312, b=312312 -> out_result=824624, ovf=0, zero=0. out_valid rises exactly SETTLE_CYCLES cycles after the accept edge; alu_op=010 held throughout SETTLE.
- aluop=00, a=2147483647, b=1 -> out_result=0x80000000, out_overflow=1, out_cout=0.
- funct=101010: a=-2147483648, b=1 -> out_result=1 (sub overflows, slt corrected). a=-123213, b=412412 -> out_result=1. a=5, b=3 -> out_result=0, out_zero=1.
- aluop=01, a=b=65512 -> alu_op=110, out_result=0, out_zero=1. funct=100100, a=0xF0, b=0x0F -> out_result=0, out_zero=1, out_cout=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> in_ready=0 and out_* stable. Then out_ready=1 -> second request accepted in the same cycle; out_valid deasserts for SETTLE_CYCLES cycles, then shows the second result.
- funct=100111 -> out_valid the cycle after accept, out_illegal=1, out_result=0. Separately, rst_n=0 for one edge during SETTLE -> next cycle out_valid=0, in_ready=1, alu_op=000, and no result is ever produced.
